// File: rtl/reg_hazard_tracker_if.sv
// reg_hazard_tracker_if: bundles the three streams around the issue scoreboard.
//   in_*  : decoded instruction offered by the instruction-buffer arbiter (valid/ready)
//   out_* : registered instruction handed to operand collection (valid/ready)
//   wb_*  : writeback beats that retire pending destination writes
// Modports:
//   master : the environment (arbiter, operand stage, writeback), drives in_*, wb_*, out_ready
//   slave  : the tracker itself
interface reg_hazard_tracker_if #(
  parameter int unsigned WIS_W   = 2,
  parameter int unsigned NR_BITS = 6,
  parameter int unsigned META_W  = 64
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIS_W-1:0]   in_wis;
  logic               in_wb;
  logic [NR_BITS-1:0] in_rd;
  logic [NR_BITS-1:0] in_rs1;
  logic [NR_BITS-1:0] in_rs2;
  logic [NR_BITS-1:0] in_rs3;
  logic [META_W-1:0]  in_meta;

  logic               out_valid;
  logic               out_ready;
  logic [WIS_W-1:0]   out_wis;
  logic               out_wb;
  logic [NR_BITS-1:0] out_rd;
  logic [NR_BITS-1:0] out_rs1;
  logic [NR_BITS-1:0] out_rs2;
  logic [NR_BITS-1:0] out_rs3;
  logic [META_W-1:0]  out_meta;

  logic               wb_valid;
  logic [WIS_W-1:0]   wb_wis;
  logic [NR_BITS-1:0] wb_rd;
  logic               wb_eop;

  modport master (
    output in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_meta,
    input  in_ready,
    input  out_valid, out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_meta,
    output out_ready,
    output wb_valid, wb_wis, wb_rd, wb_eop
  );

  modport slave (
    input  in_valid, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_meta,
    output in_ready,
    output out_valid, out_wis, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_meta,
    input  out_ready,
    input  wb_valid, wb_wis, wb_rd, wb_eop
  );

endinterface

// File: rtl/reg_hazard_tracker.sv
// reg_hazard_tracker: per-warp register scoreboard in front of operand collection.
// Holds an offered instruction while any of its sources or its destination has an
// outstanding write in the same warp; hazard-free instructions pass through a one-entry
// output register (1-cycle latency, full throughput).
// Ports:
//   clk         : clock
//   reset       : synchronous, active-high reset (clears busy bits and the output stage)
//   bus         : reg_hazard_tracker_if.slave (in_*, out_*, wb_* streams)
//   perf_stalls : hazard-stall cycle counter, saturating (only with HAZARD_PERF_EN defined)
// Optional feature macro: HAZARD_PERF_EN
module reg_hazard_tracker #(
  parameter int unsigned NUM_WARPS     = 4,
  parameter int unsigned NUM_REGS      = 64,
  parameter int unsigned NR_BITS       = 6,
  parameter int unsigned WIS_W         = 2,
  parameter int unsigned META_W        = 64,
  parameter int unsigned PERF_CTR_BITS = 44
) (
  input logic clk,
  input logic reset,
  reg_hazard_tracker_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  if (NR_BITS != $clog2(NUM_REGS)) begin : g_chk_nr
    $error("NR_BITS must equal log2(NUM_REGS)");
  end
  if (WIS_W != $clog2(NUM_WARPS)) begin : g_chk_wis
    $error("WIS_W must equal log2(NUM_WARPS)");
  end
  if (PERF_CTR_BITS == 0) begin : g_chk_perf
    $error("PERF_CTR_BITS must be non-zero");
  end

  typedef logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_t;

  busy_t busy_q, busy_d;
  busy_t rel_mask, set_mask, busy_eff;
  logic [NUM_REGS-1:0] row;

  logic rel_hit;
  logic hazard;
  logic fire_in;

  logic               out_valid_q, out_valid_d;
  logic [WIS_W-1:0]   out_wis_q;
  logic               out_wb_q;
  logic [NR_BITS-1:0] out_rd_q;
  logic [NR_BITS-1:0] out_rs1_q;
  logic [NR_BITS-1:0] out_rs2_q;
  logic [NR_BITS-1:0] out_rs3_q;
  logic [META_W-1:0]  out_meta_q;

  // Only the last beat of a writeback retires the register; r0 is never tracked.
  assign rel_hit = bus.wb_valid && bus.wb_eop && (bus.wb_rd != '0);

  always_comb begin
    rel_mask = '0;
    if (rel_hit) begin
      rel_mask[bus.wb_wis][bus.wb_rd] = 1'b1;
    end
  end

  // Same-cycle release is bypassed so a retiring writeback unblocks its consumer at once.
  assign busy_eff = busy_q & ~rel_mask;
  assign row      = busy_eff[bus.in_wis];

  // Bit 0 of every row stays clear, so r0 operands never raise a hazard.
  assign hazard = row[bus.in_rs1] | row[bus.in_rs2] | row[bus.in_rs3] |
                  (bus.in_wb & row[bus.in_rd]);

  assign bus.in_ready = ~hazard && (~out_valid_q || bus.out_ready);
  assign fire_in      = bus.in_valid && bus.in_ready;

  always_comb begin
    set_mask = '0;
    if (fire_in && bus.in_wb && (bus.in_rd != '0)) begin
      set_mask[bus.in_wis][bus.in_rd] = 1'b1;
    end
  end

  // Set is OR-ed after the clear: a new writer wins over a retiring one on the same bit.
  assign busy_d = busy_eff | set_mask;

  always_comb begin
    out_valid_d = out_valid_q;
    if (fire_in) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload needs no reset; it is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (fire_in) begin
      out_wis_q  <= bus.in_wis;
      out_wb_q   <= bus.in_wb;
      out_rd_q   <= bus.in_rd;
      out_rs1_q  <= bus.in_rs1;
      out_rs2_q  <= bus.in_rs2;
      out_rs3_q  <= bus.in_rs3;
      out_meta_q <= bus.in_meta;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_wis   = out_wis_q;
  assign bus.out_wb    = out_wb_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_rs1   = out_rs1_q;
  assign bus.out_rs2   = out_rs2_q;
  assign bus.out_rs3   = out_rs3_q;
  assign bus.out_meta  = out_meta_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_q, perf_d;

  // Stalls caused only by a full output stage are not hazards and are not counted.
  always_comb begin
    perf_d = perf_q;
    if (bus.in_valid && hazard && (perf_q != '1)) begin
      perf_d = perf_q + PERF_CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stalls = perf_q;
`endif

  // A retiring writeback must target a register that is actually pending.
  always_ff @(posedge clk) begin
    if (!reset && rel_hit) begin
      a_wb_to_busy : assert (busy_q[bus.wb_wis][bus.wb_rd])
        else $error("writeback to non-busy register w%0d r%0d", bus.wb_wis, bus.wb_rd);
    end
  end

endmodule

// File: tb/tb_reg_hazard_tracker.sv
// Directed bench for reg_hazard_tracker: reset state, RAW/WAW holds, same-cycle writeback
// bypass, warp independence, r0 handling, output back-pressure, eop gating, set-wins and
// mid-operation reset. Define HAZARD_PERF_EN for both files to also check the stall counter.
module tb_reg_hazard_tracker;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  reg_hazard_tracker_if bus_if ();

`ifdef HAZARD_PERF_EN
  logic [43:0] perf_stalls;
  reg_hazard_tracker dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .perf_stalls (perf_stalls)
  );
`else
  reg_hazard_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] wis, input logic wb, input logic [5:0] rd,
                       input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3,
                       input logic [63:0] meta);
    bus_if.in_valid = 1'b1;
    bus_if.in_wis   = wis;
    bus_if.in_wb    = wb;
    bus_if.in_rd    = rd;
    bus_if.in_rs1   = rs1;
    bus_if.in_rs2   = rs2;
    bus_if.in_rs3   = rs3;
    bus_if.in_meta  = meta;
    #1;
  endtask

  task automatic wb_beat(input logic [1:0] wis, input logic [5:0] rd, input logic eop);
    bus_if.wb_valid = 1'b1;
    bus_if.wb_wis   = wis;
    bus_if.wb_rd    = rd;
    bus_if.wb_eop   = eop;
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_wis    = '0;
    bus_if.in_wb     = 1'b0;
    bus_if.in_rd     = '0;
    bus_if.in_rs1    = '0;
    bus_if.in_rs2    = '0;
    bus_if.in_rs3    = '0;
    bus_if.in_meta   = '0;
    bus_if.out_ready = 1'b1;
    bus_if.wb_valid  = 1'b0;
    bus_if.wb_wis    = '0;
    bus_if.wb_rd     = '0;
    bus_if.wb_eop    = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // 1: reset state and first issue
    check("reset_out_valid", 64'(bus_if.out_valid), 64'd0);
`ifdef HAZARD_PERF_EN
    check("reset_perf", 64'(perf_stalls), 64'd0);
`endif
    offer(2'd0, 1'b1, 6'd5, 6'd1, 6'd2, 6'd3, 64'hA1);
    check("t1_in_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    check("t1_out_valid", 64'(bus_if.out_valid), 64'd1);
    check("t1_out_rd", 64'(bus_if.out_rd), 64'd5);
    check("t1_out_meta", bus_if.out_meta, 64'hA1);

    // 2: RAW hold, released by a same-cycle writeback
    offer(2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, 64'hA2);
    check("t2_raw_block0", 64'(bus_if.in_ready), 64'd0);
    step();
    check("t2_out_drained", 64'(bus_if.out_valid), 64'd0);
    check("t2_raw_block1", 64'(bus_if.in_ready), 64'd0);
    step();
    check("t2_raw_block2", 64'(bus_if.in_ready), 64'd0);
    wb_beat(2'd0, 6'd5, 1'b1);
    check("t2_wb_bypass", 64'(bus_if.in_ready), 64'd1);
    step();
    bus_if.wb_valid = 1'b0;
    check("t2_out_valid", 64'(bus_if.out_valid), 64'd1);
    check("t2_out_rs1", 64'(bus_if.out_rs1), 64'd5);
    check("t2_out_meta", bus_if.out_meta, 64'hA2);
`ifdef HAZARD_PERF_EN
    check("t2_perf", 64'(perf_stalls), 64'd2);
`endif
    offer(2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, 64'hA3);
    check("t2_released", 64'(bus_if.in_ready), 64'd1);
    step();
    check("t2_out_meta2", bus_if.out_meta, 64'hA3);

    // 3: warp independence
    offer(2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0, 64'hA4);
    step();
    offer(2'd1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, 64'hB1);
    check("t3_other_warp", 64'(bus_if.in_ready), 64'd1);
    step();
    check("t3_out_wis", 64'(bus_if.out_wis), 64'd1);
    check("t3_out_meta", bus_if.out_meta, 64'hB1);
    offer(2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, 64'hA5);
    check("t3_same_warp_block", 64'(bus_if.in_ready), 64'd0);
    bus_if.in_valid = 1'b0;
    wb_beat(2'd0, 6'd5, 1'b1);
    step();
    bus_if.wb_valid = 1'b0;

    // 4: r0 destination never becomes busy
    offer(2'd0, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0, 64'hC1);
    check("t4_rd0_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    check("t4_out_meta1", bus_if.out_meta, 64'hC1);
    offer(2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 64'hC2);
    check("t4_rs0_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    check("t4_out_valid", 64'(bus_if.out_valid), 64'd1);
    check("t4_out_meta2", bus_if.out_meta, 64'hC2);

    // 5: output back-pressure
    bus_if.out_ready = 1'b0;
    offer(2'd3, 1'b0, 6'd0, 6'd9, 6'd0, 6'd0, 64'hD1);
    for (int i = 0; i < 3; i++) begin
      check("t5_bp_in_ready", 64'(bus_if.in_ready), 64'd0);
      check("t5_bp_out_valid", 64'(bus_if.out_valid), 64'd1);
      check("t5_bp_out_meta", bus_if.out_meta, 64'hC2);
      step();
    end
    bus_if.out_ready = 1'b1;
    #1;
    check("t5_release_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    check("t5_out_meta", bus_if.out_meta, 64'hD1);
    check("t5_out_wis", 64'(bus_if.out_wis), 64'd3);
`ifdef HAZARD_PERF_EN
    check("t5_perf_unchanged", 64'(perf_stalls), 64'd2);
`endif

    // 6: eop gating and set-wins
    offer(2'd2, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0, 64'hE1);
    step();
    offer(2'd2, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, 64'hE2);
    wb_beat(2'd2, 6'd7, 1'b0);
    check("t6_eop0_block", 64'(bus_if.in_ready), 64'd0);
    step();
    check("t6_eop0_still_busy", 64'(bus_if.in_ready), 64'd0);
    offer(2'd2, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0, 64'hE3);
    wb_beat(2'd2, 6'd7, 1'b1);
    check("t6_waw_bypass", 64'(bus_if.in_ready), 64'd1);
    step();
    bus_if.wb_valid = 1'b0;
    check("t6_out_meta", bus_if.out_meta, 64'hE3);
    offer(2'd2, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, 64'hE4);
    check("t6_set_wins", 64'(bus_if.in_ready), 64'd0);
`ifdef HAZARD_PERF_EN
    check("t6_perf", 64'(perf_stalls), 64'd3);
`endif

    // 7: reset mid-operation
    bus_if.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7_out_valid", 64'(bus_if.out_valid), 64'd0);
    offer(2'd2, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0, 64'hF1);
    check("t7_busy_cleared", 64'(bus_if.in_ready), 64'd1);
`ifdef HAZARD_PERF_EN
    check("t7_perf", 64'(perf_stalls), 64'd0);
`endif
    step();
    check("t7_out_meta", bus_if.out_meta, 64'hF1);
    bus_if.in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
